// File: rtl/stim_seq_misr_pkg.sv
// Shared types and constants for the self-test stimulus sequencer and its MISR.
package stim_seq_misr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int VEC_W  = 8;
    localparam int MISR_W = 8;
    localparam int CNT_W  = 16;

    // Fibonacci taps 7,5,4,3 for x^8+x^6+x^5+x^4+1
    localparam logic [VEC_W-1:0]  LFSR_TAPS = 8'hB8;
    localparam logic [MISR_W-1:0] MISR_POLY = 8'h1D;

    function automatic logic [VEC_W-1:0] lfsr_next(input logic [VEC_W-1:0] v);
        return {v[VEC_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/stim_seq_misr_misr8.sv
// 8-bit multiple-input signature register compacting a 2-bit response per enabled cycle.
module misr8
    import stim_seq_misr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [MISR_W-1:0] init,
    input  logic              en,
    input  logic [1:0]        din,
    output logic [MISR_W-1:0] q
);

    logic [MISR_W-1:0] q_reg;
    logic [MISR_W-1:0] q_next;

    always_comb begin
        q_next = {q_reg[MISR_W-2:0], 1'b0}
               ^ (q_reg[MISR_W-1] ? MISR_POLY : '0)
               ^ {{(MISR_W-2){1'b0}}, din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (clear) begin
            q_reg <= init;
        end else if (en) begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/stim_seq_misr.sv
// Self-test stage: drives counter/LFSR stimulus into the combinational core and
// compacts its T/f responses into a MISR signature under a start/abort handshake.
module stim_seq_misr
    import stim_seq_misr_pkg::*;
#(
    parameter int              NUM_VEC   = 256,
    parameter logic [VEC_W-1:0] SEED      = 8'h01,
    parameter logic [MISR_W-1:0] MISR_INIT = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    output logic [3:0]        s_o,
    output logic [3:0]        r_o,
    input  logic              t_i,
    input  logic              f_i,
    output logic              busy,
    output logic              done,
    output logic [MISR_W-1:0] signature,
    output logic [CNT_W-1:0]  vec_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_VEC - 1);
    // An all-zero LFSR would lock up, so a zero seed becomes 1 in LFSR mode
    localparam logic [VEC_W-1:0] LFSR_SEED = (SEED == '0) ? 8'h01 : SEED;

    state_t             state_reg, state_next;
    logic               mode_reg;
    logic [VEC_W-1:0]   vec_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               take_start;
    logic               load;
    logic               step;

    always_comb begin
        state_next = state_reg;
        take_start = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    take_start = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort also beats the final-vector transition to DONE
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        state_next = ST_DONE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            mode_reg  <= 1'b0;
            vec_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (take_start) begin
                mode_reg <= mode;
            end
            if (load) begin
                vec_reg <= mode_reg ? LFSR_SEED : SEED;
                cnt_reg <= '0;
            end else if (step) begin
                vec_reg <= mode_reg ? lfsr_next(vec_reg) : vec_reg + 8'd1;
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    misr8 u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (load),
        .init  (MISR_INIT),
        .en    (step),
        .din   ({t_i, f_i}),
        .q     (signature)
    );

    assign s_o     = vec_reg[3:0];
    assign r_o     = vec_reg[7:4];
    assign busy    = (state_reg == ST_LOAD) || (state_reg == ST_RUN);
    assign done    = (state_reg == ST_DONE);
    assign vec_cnt = cnt_reg;

endmodule

// File: tb/tb_stim_seq_misr.sv
// Randomized scoreboard bench: a random truth table stands in for the core, and a
// polynomial-level model predicts every presented vector and each run's result.
module tb_stim_seq_misr;

    localparam int         NV = 260;
    localparam logic [7:0] SD = 8'h00;
    localparam logic [7:0] MI = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mode = 1'b0;
    logic        t_i, f_i;
    logic [3:0]  s_o, r_o;
    logic        busy, done;
    logic [7:0]  signature;
    logic [15:0] vec_cnt;
    logic [1:0]  core_tt [256];

    always #5 clk = ~clk;

    assign {t_i, f_i} = core_tt[{r_o, s_o}];

    stim_seq_misr #(.NUM_VEC(NV), .SEED(SD), .MISR_INIT(MI)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .s_o       (s_o),
        .r_o       (r_o),
        .t_i       (t_i),
        .f_i       (f_i),
        .busy      (busy),
        .done      (done),
        .signature (signature),
        .vec_cnt   (vec_cnt)
    );

    typedef struct {
        bit         aborted;
        int         cnt;
        logic [7:0] sig;
        logic [7:0] last_vec;
    } run_t;

    run_t       exp_q[$];
    logic [7:0] vec_q[$];
    int         n_checks = 0;
    int         n_fails  = 0;
    bit         skip_run = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fails++;
        $display("FAIL %s: got nothing expected an entry (t=%0t)", name, $time);
    endtask

    // Reference: multiply by x modulo x^8+x^4+x^3+x^2+1, then add the response bits
    function automatic logic [7:0] ref_misr(input logic [7:0] m, input logic [1:0] d);
        logic [8:0] x;
        x = {m, 1'b0};
        if (x[8]) x = x ^ 9'h11D;
        return x[7:0] ^ {6'b0, d};
    endfunction

    function automatic logic [7:0] ref_lfsr(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    task automatic predict(input bit md, input int abort_at);
        logic [7:0] v, m;
        int n_pres, n_abs;
        v      = (md && SD == 8'h00) ? 8'h01 : SD;
        m      = MI;
        n_pres = (abort_at != 0) ? abort_at : NV;
        n_abs  = (abort_at != 0) ? abort_at - 1 : NV;
        for (int i = 0; i < n_pres; i++) begin
            vec_q.push_back(v);
            if (i < n_abs) begin
                m = ref_misr(m, core_tt[v]);
                v = md ? ref_lfsr(v) : 8'((int'(v) + 1) % 256);
            end
        end
        exp_q.push_back('{abort_at != 0, n_abs, m, v});
    endtask

    task automatic do_run(input bit md, input int abort_at, input bit both, input int rst_at);
        bit expect_done;
        expect_done = (abort_at == 0) && (rst_at == 0);
        foreach (core_tt[i]) core_tt[i] = 2'($urandom);
        @(negedge clk);
        if (rst_at != 0) skip_run = 1'b1;
        else predict(md, abort_at);
        start = 1'b1;
        mode  = md;
        abort = both;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        mode  = 1'($urandom);
        for (int k = 1; k <= NV; k++) begin
            @(negedge clk);
            if (rst_at == k) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_s_o", {28'b0, s_o}, 0);
                chk("rst_mid_r_o", {28'b0, r_o}, 0);
                chk("rst_mid_busy", {31'b0, busy}, 0);
                chk("rst_mid_done", {31'b0, done}, 0);
                chk("rst_mid_signature", {24'b0, signature}, 0);
                chk("rst_mid_vec_cnt", {16'b0, vec_cnt}, 0);
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            start = ($urandom_range(0, 7) == 0);
            mode  = 1'($urandom);
            abort = (k == abort_at);
            if (k == abort_at) break;
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int w = 0; busy && w < 20; w++) @(negedge clk);
        chk("run_end_busy", {31'b0, busy}, 0);
        skip_run = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("abort_ignored_done", {31'b0, done}, {31'b0, expect_done});
        chk("abort_ignored_busy", {31'b0, busy}, 0);
    endtask

    // Monitor: pops presented vectors during RUN and the run result when busy falls
    initial begin
        int   cyc;
        bit   prev_busy;
        run_t e;
        cyc       = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && (busy && done)) chk("busy_done_excl", 1, 0);
            if (busy) begin
                cyc++;
                if (cyc >= 2 && !skip_run) begin
                    if (vec_q.size() == 0) fail_now("vec_underflow");
                    else chk("vec", {24'b0, r_o, s_o}, {24'b0, vec_q.pop_front()});
                end
            end else begin
                if (prev_busy && !skip_run) begin
                    if (exp_q.size() == 0) begin
                        fail_now("run_underflow");
                    end else begin
                        e = exp_q.pop_front();
                        chk("run_done", {31'b0, done}, {31'b0, !e.aborted});
                        chk("run_vec_cnt", {16'b0, vec_cnt}, e.cnt);
                        chk("run_signature", {24'b0, signature}, {24'b0, e.sig});
                        if (!e.aborted) chk("run_final_vec", {24'b0, r_o, s_o}, {24'b0, e.last_vec});
                    end
                end
                cyc = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected run completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        foreach (core_tt[i]) core_tt[i] = 2'b00;
        #12;
        chk("reset_s_o", {28'b0, s_o}, 0);
        chk("reset_r_o", {28'b0, r_o}, 0);
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_done", {31'b0, done}, 0);
        chk("reset_signature", {24'b0, signature}, 0);
        chk("reset_vec_cnt", {16'b0, vec_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_run(1'b0, 0, 1'b0, 0);     // counter, wraps FF->00
        do_run(1'b1, 0, 1'b0, 0);     // LFSR from DONE, zero seed replaced
        do_run(1'b0, 2, 1'b0, 0);     // abort on 2nd RUN cycle
        do_run(1'b0, 0, 1'b0, 0);     // full run after abort
        do_run(1'b1, NV, 1'b0, 0);    // abort on final edge wins
        do_run(1'b0, 0, 1'b1, 0);     // start+abort together in IDLE
        do_run(1'b1, 0, 1'b0, 50);    // reset mid-run
        do_run(1'b1, 0, 1'b0, 0);     // clean run after reset
        for (int r = 0; r < 6; r++) begin
            do_run(1'($urandom), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, NV)) : 0,
                   1'b0, 0);
        end

        repeat (3) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("vec_q_empty", vec_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/stim_seq_misr.md
Name: stim_seq_misr

Overview:
- Self-test wrapper stage that sits upstream of the 8-in/2-out combinational core (s[3:0], r[3:0] -> T, f).
- Generates a sequence of stimulus vectors on s/r (counter or LFSR), one per clock.
- Compacts the core's T/f responses into an 8-bit MISR signature.
- Controlled by a start/abort handshake; reports busy, done and the final signature.

Parameters:
- NUM_VEC, 256, number of vectors applied per run (1..65535).
- SEED, 8'h01, initial vector value loaded at run start.
- MISR_INIT, 8'h00, initial MISR value loaded at run start.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse or level; sampled in IDLE/DONE only.
- abort  input  1  aborts a run in progress.
- mode  input  1  0 = binary counter, 1 = LFSR; sampled at start.
- s_o  output  4  stimulus to core s[3:0] = vec[3:0].
- r_o  output  4  stimulus to core r[3:0] = vec[7:4].
- t_i  input  1  core response T.
- f_i  input  1  core response f.
- busy  output  1  high in LOAD and RUN.
- done  output  1  high in DONE.
- signature  output  8  MISR value; valid while done=1.
- vec_cnt  output  16  vectors absorbed in the current/last run.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; vec=8'h00; MISR=8'h00; vec_cnt=0; busy=0; done=0; s_o=r_o=0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: start=1 -> LOAD; latch mode.
- LOAD (1 cycle):
  - vec<=SEED; in LFSR mode SEED=0 is replaced by 8'h01.
  - MISR<=MISR_INIT; vec_cnt<=0; -> RUN.
- RUN, each cycle:
  - s_o/r_o are driven from the registered vec; the core is combinational, so t_i/f_i are valid in the same cycle.
  - At the rising edge: MISR absorbs {t_i,f_i}, vec advances, vec_cnt++.
  - When vec_cnt reaches NUM_VEC-1 at that edge (last vector absorbed) -> DONE.
  - Throughput: 1 vector/clock. Run length: LOAD + NUM_VEC RUN cycles. done rises NUM_VEC+1 cycles after the start-sampling edge.
- DONE:
  - done=1; signature and vec_cnt held; s_o/r_o hold the last-advanced vec.
  - start=1 -> LOAD (re-run).
- Counter mode: vec_next = vec+1, 8-bit wrap (8'hFF -> 8'h00).
- LFSR mode: Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - fb = vec[7]^vec[5]^vec[4]^vec[3]; vec_next = {vec[6:0], fb}.
  - Never reaches 0 from a nonzero seed.
- MISR update: m_next = {m[6:0],1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ {6'b0, t_i, f_i}.
- abort=1:
  - In LOAD/RUN: -> IDLE next edge; done stays 0; MISR/vec_cnt keep their partial values.
  - In IDLE/DONE: ignored.
  - Simultaneous with the final RUN edge: abort wins (-> IDLE, done=0).
- start while busy: ignored.
- start and abort both high in IDLE: start taken.
- mode changes during RUN: no effect.
- Reset mid-run: immediate return to reset values; no partial done.

Decomposition:
- Shared package holds:
  - state enum (IDLE/LOAD/RUN/DONE);
  - LFSR tap constant 8'hB8 (taps 7,5,4,3);
  - MISR polynomial constant 8'h1D;
  - widths VEC_W=8, MISR_W=8, CNT_W=16.
- One natural sub-module: misr8 (clk, rst_n, clear, init, en, din[1:0], q[7:0]).
- FSM and vector generator stay in the top.

Test Plan:
- Counter, SEED=0, NUM_VEC=4, t_i=f_i=0 -> s_o sequence 0,1,2,3 on cycles 2..5; signature=8'h00; vec_cnt=4; done high cycle 6 (start sampled cycle 0).
- Counter, NUM_VEC=3, t_i=1, f_i=0 constant -> MISR 8'h02, 8'h06, 8'h0E; signature=8'h0E.
- LFSR, SEED=8'h01 -> vec 01,02,04,08,11 on consecutive RUN cycles; s_o=1,2,4,8,1; r_o=0,0,0,0,1. LFSR, SEED=0 -> first vec=8'h01.
- abort asserted on 2nd RUN cycle (NUM_VEC=8) -> IDLE next cycle; done never rises; busy=0; a following start runs the full 8 vectors.
- rst_n pulsed low mid-RUN -> all outputs zero asynchronously; start after release gives the same signature as a clean run.
- Counter, SEED=8'hFE, NUM_VEC=3 -> vec FE, FF, 00 (wrap); start pulsed during RUN ignored; start in DONE re-runs and yields an identical signature.
